// File: rtl/alu_pkg.sv
// Shared opcode encodings, default datapath width and flag bundle for the RV32 execute-stage ALU.
package alu_pkg;

    localparam int ALU_WIDTH = 32;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_SLL = 3'b110;
    localparam logic [2:0] ALU_SRL = 3'b111;

    typedef struct packed {
        logic carry;
        logic zero;
        logic negative;
        logic overflow;
    } alu_flags_t;

    // SUB and SLT both run the adder in subtract mode.
    function automatic logic is_sub_op(input logic [2:0] op);
        return (op == ALU_SUB) || (op == ALU_SLT);
    endfunction

endpackage

// File: rtl/alu_addsub.sv
// Shared adder/subtractor: sum = A + (sub ? ~B + 1 : B), with carry-out and signed overflow.
module alu_addsub #(
    parameter int WIDTH = alu_pkg::ALU_WIDTH
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow
);

    logic [WIDTH-1:0] w_bop;
    logic [WIDTH:0]   w_full;

    assign w_bop  = sub ? ~B : B;
    assign w_full = {1'b0, A} + {1'b0, w_bop} + {{WIDTH{1'b0}}, sub};

    assign sum   = w_full[WIDTH-1:0];
    assign carry = w_full[WIDTH];
    // Operands of equal sign producing a result of the other sign.
    assign overflow = (A[WIDTH-1] == w_bop[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);

endmodule

// File: rtl/alu.sv
// Registered ALU: opcode mux and flag logic feeding one output register stage.
// Shift opcodes 110/111 are implemented only when ALU_SHIFT_EN is defined; otherwise they yield 0.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       ALUControl,
    output logic [WIDTH-1:0] Result,
    output logic             Carry,
    output logic             Zero,
    output logic             Negative,
    output logic             OverFlow
);

    localparam int SHAMT_W = $clog2(WIDTH);

    logic [WIDTH-1:0] w_sum;
    logic             w_add_carry;
    logic             w_add_ovf;
    logic [WIDTH-1:0] w_result;
    alu_flags_t       w_flags;

    logic [WIDTH-1:0] r_result;
    alu_flags_t       r_flags;

    alu_addsub #(.WIDTH(WIDTH)) u_addsub (
        .A        (A),
        .B        (B),
        .sub      (is_sub_op(ALUControl)),
        .sum      (w_sum),
        .carry    (w_add_carry),
        .overflow (w_add_ovf)
    );

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        w_result       = '0;
        w_flags        = '0;
        case (ALUControl)
            ALU_ADD, ALU_SUB: begin
                w_result         = w_sum;
                w_flags.carry    = w_add_carry;
                w_flags.overflow = w_add_ovf;
            end
            ALU_AND: w_result = A & B;
            ALU_OR:  w_result = A | B;
            ALU_XOR: w_result = A ^ B;
            // Signed less-than is the sign of the difference corrected by overflow.
            ALU_SLT: w_result = {{(WIDTH-1){1'b0}}, w_sum[WIDTH-1] ^ w_add_ovf};
`ifdef ALU_SHIFT_EN
            ALU_SLL: w_result = A << B[SHAMT_W-1:0];
            ALU_SRL: w_result = A >> B[SHAMT_W-1:0];
`else
            ALU_SLL, ALU_SRL: w_result = '0;
`endif
            default: w_result = '0;
        endcase
        w_flags.zero     = (w_result == '0);
        w_flags.negative = w_result[WIDTH-1];
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_result <= '0;
            r_flags  <= '0;
        end else begin
            r_result <= w_result;
            r_flags  <= w_flags;
        end
    end

    assign Result   = r_result;
    assign Carry    = r_flags.carry;
    assign Zero     = r_flags.zero;
    assign Negative = r_flags.negative;
    assign OverFlow = r_flags.overflow;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed cases plus randomized operations against an arithmetic reference model.
module tb_alu;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] A;
    logic [31:0] B;
    logic [2:0]  ALUControl;
    logic [31:0] Result;
    logic        Carry;
    logic        Zero;
    logic        Negative;
    logic        OverFlow;

    int n_cmp = 0;
    int n_mis = 0;

    alu dut (
        .clk        (clk),
        .rst        (rst),
        .A          (A),
        .B          (B),
        .ALUControl (ALUControl),
        .Result     (Result),
        .Carry      (Carry),
        .Zero       (Zero),
        .Negative   (Negative),
        .OverFlow   (OverFlow)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Reference model from plain integer arithmetic on the operand values.
    task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output logic c, output logic v);
        longint sa, sb, s;
        longint unsigned ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'(a);
        ub = longint'(b);
        r = '0; c = 1'b0; v = 1'b0;
        case (op)
            3'd0: begin
                r = a + b;
                c = (ua + ub) > 64'hFFFF_FFFF;
                s = sa + sb;
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            3'd1: begin
                r = a - b;
                c = (ua >= ub);
                s = sa - sb;
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = (sa < sb) ? 32'd1 : 32'd0;
`ifdef ALU_SHIFT_EN
            3'd6: r = a << (b % 32);
            3'd7: r = a >> (b % 32);
`endif
            default: r = '0;
        endcase
    endtask

    task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        ALUControl = op;
        A = a;
        B = b;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [31:0] r, input logic c, input logic v);
        check({tag, ".result"}, Result, r);
        check({tag, ".carry"}, {31'd0, Carry}, {31'd0, c});
        check({tag, ".zero"}, {31'd0, Zero}, {31'd0, (r == 32'd0)});
        check({tag, ".negative"}, {31'd0, Negative}, {31'd0, r[31]});
        check({tag, ".overflow"}, {31'd0, OverFlow}, {31'd0, v});
    endtask

    task automatic step(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] r, input logic c, input logic v);
        drive(op, a, b);
        expect_out(tag, r, c, v);
    endtask

    task automatic expect_reset(input string tag);
        check({tag, ".result"}, Result, 32'd0);
        check({tag, ".flags"}, {28'd0, Carry, Zero, Negative, OverFlow}, 32'd0);
    endtask

    logic [31:0] corner [5] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};

    initial begin
        logic [31:0] ra, rb, rr;
        logic [2:0]  rop;
        logic        rc, rv;

        rst = 1'b1;
        A = $urandom;
        B = $urandom;
        ALUControl = 3'($urandom_range(0, 7));
        repeat (3) @(posedge clk);
        #1;
        expect_reset("reset_hold");

        @(negedge clk);
        A = 32'd0; B = 32'd0; ALUControl = 3'b000;
        rst = 1'b0;
        @(posedge clk);
        #1;
        expect_out("first_after_reset", 32'd0, 1'b0, 1'b0);

        step("add_1_5",     3'b000, 32'h0000_0001, 32'h0000_0005, 32'h0000_0006, 1'b0, 1'b0);
        step("add_wrap",    3'b000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0);
        step("add_ovf",     3'b000, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1);
        step("slt_gt",      3'b101, 32'h0000_0011, 32'h0000_0010, 32'h0000_0000, 1'b0, 1'b0);
        step("slt_neg",     3'b101, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0);
        step("slt_ovfcorr", 3'b101, 32'h8000_0000, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0);
        step("or",          3'b011, 32'h0000_0110, 32'h1111_0000, 32'h1111_0110, 1'b0, 1'b0);
        step("and",         3'b010, 32'h0000_1111, 32'h0000_1111, 32'h0000_1111, 1'b0, 1'b0);
        step("xor_eq",      3'b100, 32'hA5A5_5A5A, 32'hA5A5_5A5A, 32'h0000_0000, 1'b0, 1'b0);
        step("sub_ovf",     3'b001, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b1);
        step("sub_borrow",  3'b001, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0);
        step("sub_equal",   3'b001, 32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1'b1, 1'b0);
`ifdef ALU_SHIFT_EN
        step("sll_4",       3'b110, 32'h0000_0001, 32'h0000_0024, 32'h0000_0010, 1'b0, 1'b0);
        step("srl_31",      3'b111, 32'h8000_0000, 32'h0000_001F, 32'h0000_0001, 1'b0, 1'b0);
        step("sll_hi_bits", 3'b110, 32'h0000_0003, 32'hFFFF_FFE1, 32'h0000_0006, 1'b0, 1'b0);
`else
        step("op110_off",   3'b110, 32'h0000_0001, 32'h0000_0024, 32'h0000_0000, 1'b0, 1'b0);
        step("op111_off",   3'b111, 32'h8000_0000, 32'h0000_001F, 32'h0000_0000, 1'b0, 1'b0);
`endif

        // Asynchronous reset mid-stream: outputs clear between edges and the in-flight op is dropped.
        step("pre_async", 3'b000, 32'h4000_0000, 32'h4000_0000, 32'h8000_0000, 1'b0, 1'b1);
        @(negedge clk);
        A = 32'hFFFF_FFFF; B = 32'h0000_0002; ALUControl = 3'b000;
        #2;
        rst = 1'b1;
        #1;
        expect_reset("async_reset");
        @(posedge clk);
        #1;
        expect_reset("reset_edge");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        expect_out("resume", 32'h0000_0001, 1'b1, 1'b0);

        for (int i = 0; i < 300; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
            rb = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
            model(rop, ra, rb, rr, rc, rv);
            step($sformatf("rand%0d_op%0d", i, rop), rop, ra, rb, rr, rc, rv);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
